// File: rtl/fetch_buffer.sv
// Fetch-to-decode packet queue: DEPTH entries of {pc, 4 instructions, slot mask}.
// Latency: a packet written on edge N is presented on the o_* outputs after edge N; no bypass.
// Backpressure: o_ready drops only when every entry is occupied; o_valid/i_ready drains the head; i_kill flushes.
module fetch_buffer #(
   parameter int DEPTH          = 4,   // power of two, at least 2
   parameter int ADDR_MEM_WIDTH = 32
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_valid,
   input  logic [ADDR_MEM_WIDTH-1:0]   i_pc,
   input  logic [127:0]                i_instr4x,
   input  logic [3:0]                  i_imask,
   output logic                        o_ready,
   output logic                        o_valid,
   output logic [ADDR_MEM_WIDTH-1:0]   o_pc,
   output logic [127:0]                o_instr4x,
   output logic [3:0]                  o_imask,
   input  logic                        i_ready,
   input  logic                        i_kill,
   output logic [$clog2(DEPTH):0]      o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // One stored fetch packet.
   typedef struct packed {
      logic [ADDR_MEM_WIDTH-1:0] pc;
      logic [127:0]              instr4x;
      logic [3:0]                imask;
   } entry_t;

   entry_t             mem [DEPTH];
   entry_t             head_ent;
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   count;
   logic               enq;
   logic               deq;

   // Flow-control status depends on registered occupancy only, so o_ready
   // never combinationally follows i_ready.
   assign o_ready = (count != CNT_W'(DEPTH));
   assign o_valid = (count != '0);
   assign o_count = count;

   // A packet with no valid slot carries nothing for decode and is dropped.
   // Kill suppresses both sides so the flush leaves a clean empty queue.
   assign enq = i_valid & o_ready & ~i_kill & (i_imask != 4'b0000);
   assign deq = o_valid & i_ready & ~i_kill;

   // Packet storage: written at the tail; deliberately not cleared by reset or
   // kill since the pointers alone define which entries are live.
   always_ff @(posedge i_clk) begin
      if (enq) begin
         mem[tail] <= '{pc: i_pc, instr4x: i_instr4x, imask: i_imask};
      end
   end

   // Head/tail pointers and occupancy; kill returns everything to slot 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (i_kill) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + PTR_W'(1);
         if (deq) head <= head + PTR_W'(1);
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Present the head entry; outputs read as zero whenever the queue is empty,
   // which also makes them clear immediately on asynchronous reset.
   always_comb begin
      head_ent  = mem[head];
      o_pc      = '0;
      o_instr4x = '0;
      o_imask   = '0;
      if (o_valid) begin
         o_pc      = head_ent.pc;
         o_instr4x = head_ent.instr4x;
         o_imask   = head_ent.imask;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH=4): table of per-cycle vectors plus
// hand-written asynchronous-reset sequences. Expected values are hand-computed.
module tb_fetch_buffer;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [31:0]  in_pc;
   logic [127:0] in_instr;
   logic [3:0]   in_mask;
   logic         out_ready;
   logic         out_valid;
   logic [31:0]  out_pc;
   logic [127:0] out_instr;
   logic [3:0]   out_mask;
   logic         dec_ready;
   logic         kill;
   logic [2:0]   count;

   int total = 0;
   int bad   = 0;

   fetch_buffer #(.DEPTH(4), .ADDR_MEM_WIDTH(32)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_valid   (in_valid),
      .i_pc      (in_pc),
      .i_instr4x (in_instr),
      .i_imask   (in_mask),
      .o_ready   (out_ready),
      .o_valid   (out_valid),
      .o_pc      (out_pc),
      .o_instr4x (out_instr),
      .o_imask   (out_mask),
      .i_ready   (dec_ready),
      .i_kill    (kill),
      .o_count   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction payload derived from the PC so each packet is distinguishable.
   function automatic logic [127:0] instr_of(input logic [31:0] pc);
      return {pc ^ 32'h0000_000C, pc ^ 32'h0000_0008, pc ^ 32'h0000_0004, pc ^ 32'h0000_0013};
   endfunction

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [3:0]  m;
      logic        r;
      logic        k;
      logic        ev;
      logic        er;
      logic [2:0]  ec;
      logic [31:0] epc;
      logic [3:0]  em;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic [31:0] pc, input logic [3:0] m,
                      input logic r, input logic k, input logic ev, input logic er,
                      input logic [2:0] ec, input logic [31:0] epc, input logic [3:0] em);
      vec_t t;
      t.v = v; t.pc = pc; t.m = m; t.r = r; t.k = k;
      t.ev = ev; t.er = er; t.ec = ec; t.epc = epc; t.em = em;
      tbl.push_back(t);
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Compare every output against an expected state.
   task automatic chk_state(input string tag, input logic ev, input logic er,
                            input logic [2:0] ec, input logic [31:0] epc, input logic [3:0] em);
      chk({tag, ".valid"}, 128'(out_valid), 128'(ev));
      chk({tag, ".ready"}, 128'(out_ready), 128'(er));
      chk({tag, ".count"}, 128'(count),     128'(ec));
      chk({tag, ".pc"},    128'(out_pc),    128'(epc));
      chk({tag, ".mask"},  128'(out_mask),  128'(em));
      chk({tag, ".instr"}, out_instr, ev ? instr_of(epc) : 128'd0);
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] m,
                        input logic r, input logic k);
      in_valid  = v;
      in_pc     = pc;
      in_instr  = instr_of(pc);
      in_mask   = m;
      dec_ready = r;
      kill      = k;
   endtask

   // Called #1 after a rising edge: drive, confirm no same-cycle bypass,
   // clock once, then compare the post-edge state.
   task automatic apply(input vec_t t, input string tag, input logic [2:0] prev_cnt);
      drive(t.v, t.pc, t.m, t.r, t.k);
      #2;
      chk({tag, ".pre_count"}, 128'(count), 128'(prev_cnt));
      @(posedge clk);
      #1;
      chk_state(tag, t.ev, t.er, t.ec, t.epc, t.em);
   endtask

   initial begin
      logic [2:0] prev;

      // Reset, with a packet presented that must not be captured.
      rst_n = 1'b0;
      drive(1'b1, 32'hDEAD_0000, 4'hF, 1'b0, 1'b0);
      #1;
      chk_state("reset", 1'b0, 1'b1, 3'd0, 32'h0, 4'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_state("reset_hold", 1'b0, 1'b1, 3'd0, 32'h0, 4'h0);
      drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk_state("post_reset", 1'b0, 1'b1, 3'd0, 32'h0, 4'h0);

      //   v  pc            m     r  k   ev er cnt epc           em
      // single packet then dequeue
      add(1, 32'h100, 4'hF, 0, 0,  1, 1, 1, 32'h100, 4'hF);
      add(0, 32'h0,   4'h0, 1, 0,  0, 1, 0, 32'h0,   4'h0);
      // fill to full with decode stalled
      add(1, 32'h00,  4'hF, 0, 0,  1, 1, 1, 32'h00,  4'hF);
      add(1, 32'h10,  4'hF, 0, 0,  1, 1, 2, 32'h00,  4'hF);
      add(1, 32'h20,  4'hF, 0, 0,  1, 1, 3, 32'h00,  4'hF);
      add(1, 32'h30,  4'hF, 0, 0,  1, 0, 4, 32'h00,  4'hF);
      add(1, 32'h40,  4'hF, 0, 0,  1, 0, 4, 32'h00,  4'hF);   // held while full
      add(1, 32'h40,  4'hF, 1, 0,  1, 1, 3, 32'h10,  4'hF);   // dequeue only, no enq into full
      add(1, 32'h40,  4'hF, 0, 0,  1, 0, 4, 32'h10,  4'hF);   // 0x40 accepted
      add(0, 32'h0,   4'h0, 1, 0,  1, 1, 3, 32'h20,  4'hF);
      add(0, 32'h0,   4'h0, 1, 0,  1, 1, 2, 32'h30,  4'hF);
      add(0, 32'h0,   4'h0, 1, 0,  1, 1, 1, 32'h40,  4'hF);
      add(0, 32'h0,   4'h0, 1, 0,  0, 1, 0, 32'h0,   4'h0);
      add(0, 32'h0,   4'h0, 1, 0,  0, 1, 0, 32'h0,   4'h0);   // ready ignored when empty
      // streaming across pointer wrap: count stays 1, output = input delayed one cycle
      for (int i = 0; i < 12; i++)
         add(1, 32'h1000 + 32'(i) * 32'h10, 4'hF, 1, 0,
             1, 1, 1, 32'h1000 + 32'(i) * 32'h10, 4'hF);
      add(0, 32'h0,   4'h0, 1, 0,  0, 1, 0, 32'h0,   4'h0);
      // empty-mask drop
      add(1, 32'h200, 4'h0, 0, 0,  0, 1, 0, 32'h0,   4'h0);
      add(1, 32'h210, 4'h5, 0, 0,  1, 1, 1, 32'h210, 4'h5);
      add(1, 32'h220, 4'h0, 0, 0,  1, 1, 1, 32'h210, 4'h5);   // dropped while non-empty
      add(0, 32'h0,   4'h0, 1, 0,  0, 1, 0, 32'h0,   4'h0);
      // kill priority with count=3 and simultaneous enq/deq
      add(1, 32'h300, 4'hF, 0, 0,  1, 1, 1, 32'h300, 4'hF);
      add(1, 32'h310, 4'h3, 0, 0,  1, 1, 2, 32'h300, 4'hF);
      add(1, 32'h320, 4'h8, 0, 0,  1, 1, 3, 32'h300, 4'hF);
      add(1, 32'h330, 4'hF, 1, 1,  0, 1, 0, 32'h0,   4'h0);
      add(0, 32'h0,   4'h0, 1, 0,  0, 1, 0, 32'h0,   4'h0);   // killed packet absent
      add(1, 32'h340, 4'h6, 0, 0,  1, 1, 1, 32'h340, 4'h6);
      // kill while full
      add(1, 32'h350, 4'hF, 0, 0,  1, 1, 2, 32'h340, 4'h6);
      add(1, 32'h360, 4'hF, 0, 0,  1, 1, 3, 32'h340, 4'h6);
      add(1, 32'h370, 4'hF, 0, 0,  1, 0, 4, 32'h340, 4'h6);
      add(0, 32'h0,   4'h0, 0, 1,  0, 1, 0, 32'h0,   4'h0);
      add(1, 32'h380, 4'h1, 0, 0,  1, 1, 1, 32'h380, 4'h1);
      add(1, 32'h390, 4'h2, 0, 0,  1, 1, 2, 32'h380, 4'h1);

      prev = 3'd0;
      foreach (tbl[i]) begin
         apply(tbl[i], $sformatf("vec%0d", i), prev);
         prev = tbl[i].ec;
      end

      // Asynchronous reset between edges with count=2.
      drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      chk_state("async_rst", 1'b0, 1'b1, 3'd0, 32'h0, 4'h0);
      // Packet offered during reset is discarded.
      drive(1'b1, 32'h600, 4'hF, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk_state("rst_discard", 1'b0, 1'b1, 3'd0, 32'h0, 4'h0);
      drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk_state("rst_release", 1'b0, 1'b1, 3'd0, 32'h0, 4'h0);
      // Pointers restart at slot 0: two packets come out in order.
      drive(1'b1, 32'h700, 4'hC, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(1'b1, 32'h710, 4'h3, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk_state("after_rst_a", 1'b1, 1'b1, 3'd1, 32'h710, 4'h3);
      drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk_state("after_rst_b", 1'b0, 1'b1, 3'd0, 32'h0, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
